// File: rtl/wr_ptr_ctrl_pkg.sv
// Shared async-FIFO helpers: default pointer geometry and gray/binary conversion.
// The conversion functions work on a wide zero-extended vector so that any
// pointer width up to MAX_PTR_W can use them; callers truncate the result.
package wr_ptr_ctrl_pkg;

  localparam int MAX_PTR_W = 32;
  localparam int PTR_W     = 5;
  localparam int DEPTH     = 1 << PTR_W;

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // MSB-down XOR chain; zero upper bits of a narrow pointer pass through as zero.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a gray-coded pointer crossing clock domains.
// Shared by the write side (read pointer) and the read side (write pointer).
module gray_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the pointer one stage per clock; stage 0 is the only flop that sees the async input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller of the async FIFO: accepts writes while not
// full, advances binary and gray write pointers, synchronizes the read pointer
// and produces full / almost-full / overflow flags.
//
// Handshake: wr_en_i is the producer's request (valid); the FIFO is ready when
// wr_full_o is low and reset is released. A transfer happens in exactly the
// cycles where wr_fire_o is high; a request while full is dropped and reported
// on wr_overflow_o the next cycle.
module wr_ptr_ctrl
  import wr_ptr_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH    = PTR_W,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                 wr_clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [PTR_WIDTH:0]   rptr_gray_i,
  output logic                 wr_fire_o,
  output logic [PTR_WIDTH-1:0] waddr_o,
  output logic [PTR_WIDTH:0]   wptr_bin_o,
  output logic [PTR_WIDTH:0]   wptr_gray_o,
  output logic [PTR_WIDTH:0]   rp2wp_gray_o,
  output logic                 wr_full_o,
  output logic                 wr_almost_full_o,
  output logic                 wr_overflow_o
);

  localparam int            PW        = PTR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_nxt;
  logic [PW-1:0] wgray_nxt;
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_nxt;
  logic [PW-1:0] full_cmp;

  // Read pointer brought into the write clock domain.
  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (wr_clk_i),
    .rst (rst_i),
    .d   (rptr_gray_i),
    .q   (rp2wp_gray_o)
  );

  assign wr_fire_o = wr_en_i & ~wr_full_o & ~rst_i;
  assign waddr_o   = wptr_bin_o[PTR_WIDTH-1:0];

  // Next pointers; the flags below look at these so that the write that fills
  // the FIFO raises full on the same edge that moves the pointer.
  assign wbin_nxt  = wptr_bin_o + PW'(wr_fire_o);
  assign wgray_nxt = PW'(bin2gray(MAX_PTR_W'(wbin_nxt)));
  assign rbin      = PW'(gray2bin(MAX_PTR_W'(rp2wp_gray_o)));
  assign fill_nxt  = wbin_nxt - rbin;

  // Full when the write pointer is one lap ahead: in gray code that means the
  // top two bits are inverted and the rest match.
  assign full_cmp = {~rp2wp_gray_o[PW-1:PW-2], rp2wp_gray_o[PW-3:0]};

  // Register pointers and flags; gray is stored so only one bit toggles per write.
  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_bin_o       <= '0;
      wptr_gray_o      <= '0;
      wr_full_o        <= 1'b0;
      wr_almost_full_o <= 1'b0;
      wr_overflow_o    <= 1'b0;
    end else begin
      wptr_bin_o       <= wbin_nxt;
      wptr_gray_o      <= wgray_nxt;
      wr_full_o        <= (wgray_nxt == full_cmp);
      wr_almost_full_o <= (fill_nxt >= AFULL_LVL);
      wr_overflow_o    <= wr_en_i & wr_full_o;
    end
  end

endmodule
